byte_decode_stream: RTL and testbench



---
 rtl/byte_decode_pkg.sv | 30 +++
 rtl/byte_decode_stream_bit_accumulator.sv | 45 ++++
 rtl/byte_decode_stream.sv | 114 +++++++++++
 tb/tb_byte_decode_stream.sv | 306 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/byte_decode_pkg.sv
// byte_decode_pkg: shared constants and types for the streaming ByteDecode_d unit.
// Imported by the accumulator and the top level.
package byte_decode_pkg;

    localparam int N_COEF = 256;
    localparam int D_MAX  = 12;
    localparam int Q      = 3329;
    localparam int BUF_W  = D_MAX + 8;

    localparam int DW   = $clog2(D_MAX + 1);
    localparam int CW   = $clog2(BUF_W + 1);
    localparam int BL_W = $clog2(N_COEF * D_MAX / 8 + 1);
    localparam int CC_W = $clog2(N_COEF + 1);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    typedef logic [D_MAX-1:0] coef_t;
    typedef logic [DW-1:0]    d_t;
    typedef logic [CW-1:0]    cnt_t;

    // Bytes needed for one job of width d (N_COEF is a multiple of 8).
    function automatic logic [BL_W-1:0] bytes_for(input d_t d);
        return BL_W'((N_COEF / 8) * int'(d));
    endfunction

endpackage

// File: rtl/byte_decode_stream_bit_accumulator.sv
// bit_accumulator: narrow LSB-first bit buffer.
// Bytes land above the valid bits; coefficients leave from bit 0.
module bit_accumulator
    import byte_decode_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             push,
    input  logic             pop,
    input  logic [7:0]       din,
    input  d_t               d,
    output logic [BUF_W-1:0] acc,
    output cnt_t             bit_cnt
);

    logic [BUF_W-1:0] shifted;
    logic [BUF_W-1:0] placed;
    cnt_t             base;

    // Shift out a popped coefficient first, then place the new byte on top.
    always_comb begin
        shifted = pop ? (acc >> d) : acc;
        base    = pop ? (bit_cnt - cnt_t'(d)) : bit_cnt;
        placed  = '0;
        if (push) begin
            placed = BUF_W'(din) << base;
        end
    end

    // Buffer and fill level; bits above bit_cnt are always zero.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            acc     <= '0;
            bit_cnt <= '0;
        end else if (clr) begin
            acc     <= '0;
            bit_cnt <= '0;
        end else begin
            acc     <= shifted | placed;
            bit_cnt <= base + (push ? cnt_t'(8) : cnt_t'(0));
        end
    end

endmodule

// File: rtl/byte_decode_stream.sv
// byte_decode_stream: streaming ByteDecode_d, bytes in, d-bit coefficients out.
// Holds the job FSM, byte/coefficient counters and the mod-Q stage.
module byte_decode_stream
    import byte_decode_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [DW-1:0]    cfg_d,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [7:0]       in_byte,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [D_MAX-1:0] out_coef,
    output logic             busy,
    output logic             done,
    output logic             err
);

    state_t           state;
    d_t               d_q;
    logic [BL_W-1:0]  bytes_left;
    logic [CC_W-1:0]  coef_cnt;
    logic [BUF_W-1:0] acc;
    cnt_t             bit_cnt;
    logic             cfg_ok;
    logic             start_ok;
    logic             push;
    logic             pop;
    coef_t            mask;
    coef_t            raw;

    assign cfg_ok   = (cfg_d != '0) && (cfg_d <= d_t'(D_MAX));
    assign start_ok = (state == IDLE) && start && cfg_ok;

    assign in_ready  = (state == RUN) && (bytes_left != '0)
                     && (bit_cnt <= cnt_t'(BUF_W - 8));
    assign out_valid = (state == RUN) && (bit_cnt >= cnt_t'(d_q));

    assign push = in_valid && in_ready;
    assign pop  = out_valid && out_ready;

    bit_accumulator u_acc (
        .clk     (clk),
        .rst_n   (rst_n),
        .clr     (start_ok),
        .push    (push),
        .pop     (pop),
        .din     (in_byte),
        .d       (d_q),
        .acc     (acc),
        .bit_cnt (bit_cnt)
    );

    // Low d bits of the buffer, with a single conditional subtract at d = D_MAX.
    always_comb begin
        mask     = ~({D_MAX{1'b1}} << d_q);
        raw      = acc[D_MAX-1:0] & mask;
        out_coef = raw;
        if ((d_q == d_t'(D_MAX)) && (raw >= coef_t'(Q))) begin
            out_coef = raw - coef_t'(Q);
        end
    end

    // Job FSM with registered busy/done/err pulses.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= IDLE;
            d_q        <= '0;
            bytes_left <= '0;
            coef_cnt   <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
            err        <= 1'b0;
        end else begin
            done <= 1'b0;
            err  <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (start && cfg_ok) begin
                        state      <= RUN;
                        d_q        <= cfg_d;
                        bytes_left <= bytes_for(cfg_d);
                        coef_cnt   <= '0;
                        busy       <= 1'b1;
                    end else if (start) begin
                        err <= 1'b1;
                    end
                end
                RUN: begin
                    if (push) begin
                        bytes_left <= bytes_left - 1'b1;
                    end
                    if (pop) begin
                        coef_cnt <= coef_cnt + 1'b1;
                        if (coef_cnt == CC_W'(N_COEF - 1)) begin
                            state <= DONE;
                            busy  <= 1'b0;
                            done  <= 1'b1;
                        end
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_byte_decode_stream.sv
// tb_byte_decode_stream: randomized scoreboard bench for byte_decode_stream.
// Expected coefficients come from a bit-level model of the byte stream.
module tb_byte_decode_stream;
    import byte_decode_pkg::*;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             start;
    logic [DW-1:0]    cfg_d;
    logic             in_valid;
    logic             in_ready;
    logic [7:0]       in_byte;
    logic             out_valid;
    logic             out_ready;
    logic [D_MAX-1:0] out_coef;
    logic             busy;
    logic             done;
    logic             err;

    byte_decode_stream dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .cfg_d     (cfg_d),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_byte   (in_byte),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_coef  (out_coef),
        .busy      (busy),
        .done      (done),
        .err       (err)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    logic [7:0] stim[$];
    int         exp_q[$];
    int         got[$];
    int         hs_cyc[$];
    int         cyc      = 0;
    int         acc_cnt  = 0;
    int         drv_idx  = 0;
    bit         drv_on   = 0;
    int         in_prob  = 100;
    int         out_prob = 100;
    int         done_cnt = 0;
    int         err_cnt  = 0;
    bit         held_v   = 0;
    int         held     = 0;

    task automatic check(input string name, input int act, input int req);
        total++;
        if (act != req) begin
            bad++;
            $display("FAIL %s: got %0d want %0d", name, act, req);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // Byte driver: counts acceptances, offers filler once the job's bytes run out.
    initial begin
        in_valid = 1'b0;
        in_byte  = 8'h00;
        forever begin
            @(negedge clk);
            if (in_valid && in_ready && rst_n) begin
                acc_cnt++;
                drv_idx++;
            end
            @(posedge clk);
            #1;
            if (drv_on && ($urandom_range(99) < 32'(in_prob))) begin
                in_valid = 1'b1;
                in_byte  = (drv_idx < stim.size()) ? stim[drv_idx] : 8'h5A;
            end else begin
                in_valid = 1'b0;
            end
        end
    end

    // Output back-pressure.
    initial begin
        out_ready = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            out_ready = ($urandom_range(99) < 32'(out_prob));
        end
    end

    // Monitor: scoreboard pops, stall stability, pulse counting.
    initial begin
        forever begin
            @(negedge clk);
            if (done) done_cnt++;
            if (err) err_cnt++;
            if (!rst_n) begin
                held_v = 0;
            end else begin
                if (held_v) begin
                    check("stall_valid", int'(out_valid), 1);
                    check("stall_coef", int'(out_coef), held);
                end
                held_v = 0;
                if (out_valid && out_ready) begin
                    hs_cyc.push_back(cyc);
                    got.push_back(int'(out_coef));
                    if (exp_q.size() == 0) begin
                        total++;
                        bad++;
                        $display("FAIL extra_coef: got %0d want none", out_coef);
                    end else begin
                        check("coef", int'(out_coef), exp_q.pop_front());
                    end
                end else if (out_valid) begin
                    held_v = 1;
                    held   = int'(out_coef);
                end
            end
        end
    end

    task automatic gen(input int d);
        stim.delete();
        for (int i = 0; i < N_COEF * d / 8; i++) begin
            stim.push_back(8'($urandom));
        end
    endtask

    // Reference: coefficient k is stream bits k*d .. k*d+d-1, LSB first.
    task automatic model(input int d);
        exp_q.delete();
        for (int k = 0; k < N_COEF; k++) begin
            int v = 0;
            for (int b = 0; b < d; b++) begin
                int p = k * d + b;
                if (stim[p / 8][p % 8]) v += (1 << b);
            end
            if (d == D_MAX && v >= Q) v -= Q;
            exp_q.push_back(v);
        end
    endtask

    task automatic do_start(input int d);
        @(posedge clk);
        #1;
        start = 1'b1;
        cfg_d = DW'(d);
        @(posedge clk);
        #1;
        start = 1'b0;
        cfg_d = DW'($urandom);
    endtask

    task automatic launch(input int d);
        got.delete();
        hs_cyc.delete();
        acc_cnt = 0;
        drv_idx = 0;
        model(d);
        drv_on = 1;
        do_start(d);
    endtask

    task automatic finish_job(input string tag, input int d, input int d0);
        int t = 0;
        while (done_cnt == d0 && t < 20000) begin
            @(posedge clk);
            t++;
        end
        check({tag, "_no_timeout"}, int'(t < 20000), 1);
        repeat (6) @(posedge clk);
        @(negedge clk);
        check({tag, "_done_pulses"}, done_cnt - d0, 1);
        check({tag, "_bytes"}, acc_cnt, N_COEF * d / 8);
        check({tag, "_coefs"}, got.size(), N_COEF);
        check({tag, "_left"}, exp_q.size(), 0);
        check({tag, "_in_ready"}, int'(in_ready), 0);
        check({tag, "_busy"}, int'(busy), 0);
        drv_on = 0;
    endtask

    initial begin
        int pat[8];
        int d0;
        int e0;
        int t;
        pat = '{1, 0, 1, 0, 0, 1, 0, 1};
        rst_n = 1'b0;
        start = 1'b0;
        cfg_d = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_in_ready", int'(in_ready), 0);
        check("rst_out_valid", int'(out_valid), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_done", int'(done), 0);
        check("rst_err", int'(err), 0);
        check("rst_coef", int'(out_coef), 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // d=1 with a known first byte
        gen(1);
        stim[0] = 8'hA5;
        in_prob = 70;
        out_prob = 70;
        d0 = done_cnt;
        launch(1);
        finish_job("d1", 1, d0);
        for (int i = 0; i < 8; i++) check("d1_bit", got[i], pat[i]);

        // d=12 with the mod-Q example at the head
        gen(12);
        stim[0] = 8'h01;
        stim[1] = 8'hD0;
        stim[2] = 8'hFF;
        d0 = done_cnt;
        launch(12);
        finish_job("d12", 12, d0);
        check("d12_c0", got[0], 1);
        check("d12_c1", got[1], 764);

        // d=11 gapped input, random back-pressure, start while busy
        gen(11);
        in_prob = 60;
        out_prob = 50;
        d0 = done_cnt;
        e0 = err_cnt;
        launch(11);
        repeat (50) @(posedge clk);
        @(negedge clk);
        check("d11_busy", int'(busy), 1);
        do_start(3);
        do_start(0);
        finish_job("d11", 11, d0);
        check("d11_no_err", err_cnt, e0);

        // d=8 full throughput
        gen(8);
        in_prob = 100;
        out_prob = 100;
        d0 = done_cnt;
        launch(8);
        finish_job("d8", 8, d0);
        check("d8_rate", hs_cyc[N_COEF-1] - hs_cyc[0], N_COEF - 1);

        // illegal widths
        e0 = err_cnt;
        do_start(0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("err_d0", err_cnt - e0, 1);
        check("err_d0_busy", int'(busy), 0);
        do_start(13);
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("err_d13", err_cnt - e0, 2);
        check("err_d13_busy", int'(busy), 0);

        // reset mid-job, then a fresh job
        gen(4);
        in_prob = 70;
        out_prob = 70;
        d0 = done_cnt;
        launch(4);
        t = 0;
        while (got.size() < 100 && t < 5000) begin
            @(posedge clk);
            t++;
        end
        check("rst_mid_reached", int'(got.size() >= 100), 1);
        #1;
        rst_n = 1'b0;
        drv_on = 0;
        @(posedge clk);
        @(negedge clk);
        check("mid_in_ready", int'(in_ready), 0);
        check("mid_out_valid", int'(out_valid), 0);
        check("mid_busy", int'(busy), 0);
        check("mid_done", int'(done), 0);
        check("mid_err", int'(err), 0);
        check("mid_coef", int'(out_coef), 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        exp_q.delete();
        repeat (3) @(posedge clk);
        check("mid_no_done", done_cnt, d0);
        gen(4);
        d0 = done_cnt;
        launch(4);
        finish_job("d4", 4, d0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
